multiplicacao_matrizes_seq: RTL and testbench
=============================================

MULTIPLICACAO_MATRIZES_SEQ -- requirements
Module: multiplicacao_matrizes_seq

Interface
REQ-001 Parameter DATA_W, default 8, sets the signed two's-complement element width.
REQ-002 Parameter MAX_N, default 5, sets the largest supported square dimension.
REQ-003 Parameter SATURATE, default 0: 0 wraps results to the low DATA_W bits, 1 clamps them to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-004 Port clk, input, 1 bit: single clock, rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-007 Port size, input, SW=$clog2(MAX_N+1) bits: dimension N, binary encoded (2 means 2x2).
REQ-008 Port A, input, MAX_N*MAX_N*DATA_W bits: element (i,j) occupies [(i*MAX_N+j)*DATA_W +: DATA_W].
REQ-009 Port B, input, MAX_N*MAX_N*DATA_W bits: same layout as A.
REQ-010 Port C, output, MAX_N*MAX_N*DATA_W bits: product matrix, same layout, registered.
REQ-011 Port busy, output, 1 bit: high while an operation runs.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port overflow_flag, output, 1 bit: sticky per operation, set if any element exceeds the DATA_W signed range.
REQ-014 Port size_err, output, 1 bit: set when the requested N is 0 or greater than MAX_N.

Function
REQ-015 The block SHALL use a two-state FSM: IDLE and RUN.
REQ-016 In IDLE, start=1 with a valid N SHALL latch A, B and N, clear C, overflow_flag and size_err, and enter RUN with busy=1 from that edge.
REQ-017 In RUN, the block SHALL perform exactly one signed DATA_W x DATA_W multiply-accumulate per cycle.
- Iteration order: k innermost, then j, then i, each from 0 to N-1.
REQ-018 The accumulator SHALL be 2*DATA_W+$clog2(MAX_N) bits wide and SHALL clear at k=0 of each element.
REQ-019 On the k=N-1 cycle, the block SHALL write the final sum to C(i,j) on the same edge, wrapped or saturated per SATURATE.
REQ-020 overflow_flag SHALL set if any final sum falls outside the DATA_W signed range, in either mode.
REQ-021 Latency SHALL be N^3 cycles from the start edge to the edge that writes the last element.
- That edge returns the FSM to IDLE, drops busy and raises done for exactly one cycle.
- N=2 gives 8 cycles; N=5 gives 125 cycles.
REQ-022 Elements of C with i>=N or j>=N SHALL read as zero.
REQ-023 C, overflow_flag and size_err SHALL hold their values until the next accepted start.
REQ-024 start SHALL be ignored while busy=1.
- Operands latched at the start edge SHALL be the only ones used; later changes to A, B or size have no effect.
REQ-025 start during the done cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-026 start with an invalid N SHALL not enter RUN; on the next cycle it SHALL produce done=1, size_err=1, C=0, overflow_flag=0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, C=0, busy=0, done=0, overflow_flag=0, size_err=0, and clear all indices, the accumulator and the operand latches.
REQ-028 Reset mid-RUN SHALL abort the operation with no done pulse.
REQ-029 The first start after reset release SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the default DATA_W and MAX_N, and functions for element offset and accumulator width.
REQ-031 One sub-module, mac_signed, SHALL hold the signed multiplier and accumulator, with clear and enable inputs, parametrised by DATA_W and accumulator width.

Verification
REQ-032 Identity test: N=2, A=identity, B=[[1,2],[3,4]], start 1 cycle -> done exactly 8 cycles later, C=[[1,2],[3,4]], other elements 0, overflow_flag=0.
REQ-033 Wrap/saturate test: N=3, all elements 127 -> each sum is 48387; with SATURATE=0 every C element = 8'h03, with SATURATE=1 every element = 127; overflow_flag=1 in both.
REQ-034 Negative test: N=5, all elements -128, SATURATE=1 -> each sum is 81920, C elements = 127, overflow_flag=1, done after 125 cycles.
REQ-035 Reset mid-run: N=5 run with rst_n=0 pulsed at cycle 50 -> all outputs 0 immediately, no done pulse; a following N=2 start completes in 8 cycles.
REQ-036 Invalid size and ignored start: size=0 -> done and size_err on the next cycle, C=0; a start asserted while busy -> ignored, result unchanged.

Source files
------------

// File: rtl/multiplicacao_matrizes_seq_pkg.sv
// Shared constants and helpers for the sequential signed matrix multiplier.
package multiplicacao_matrizes_seq_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_N  = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int elem_off(input int i, input int j, input int max_n, input int data_w);
    return (i * max_n + j) * data_w;
  endfunction

  function automatic int acc_width(input int data_w, input int max_n);
    return 2 * data_w + $clog2(max_n);
  endfunction
endpackage

// File: rtl/multiplicacao_matrizes_seq_mac.sv
// Signed MAC: sum is the combinational running total, committed to the accumulator when enabled.
module mac_signed #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x, base, acc_q, acc_d;

  assign prod   = a * b;
  assign prod_x = ACC_W'(prod);
  // clr starts a fresh element without needing a separate clearing cycle
  assign base   = clr ? '0 : acc_q;
  assign sum    = base + prod_x;

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/multiplicacao_matrizes_seq.sv
// Sequential NxN signed matrix multiply, one MAC per cycle, k innermost then j then i.
module multiplicacao_matrizes_seq
  import multiplicacao_matrizes_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_N    = DEF_MAX_N,
  parameter int SATURATE = 0,
  localparam int SW      = $clog2(MAX_N + 1),
  localparam int MW      = MAX_N * MAX_N * DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] size,
  input  logic [MW-1:0] A,
  input  logic [MW-1:0] B,
  output logic [MW-1:0] C,
  output logic          busy,
  output logic          done,
  output logic          overflow_flag,
  output logic          size_err
);
  localparam int ACC_W = acc_width(DATA_W, MAX_N);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic [SW-1:0] MAXN_S = SW'(MAX_N);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic          done_q, done_d, ovf_q, ovf_d, serr_q, serr_d;

  logic signed [DATA_W-1:0] a_el, b_el;
  logic signed [ACC_W-1:0]  sum;
  logic [DATA_W-1:0]        res;
  logic                     ovf_el, size_ok;
  logic [SW-1:0]            n_m1;

  assign a_el    = a_q[elem_off(int'(i_q), int'(k_q), MAX_N, DATA_W) +: DATA_W];
  assign b_el    = b_q[elem_off(int'(k_q), int'(j_q), MAX_N, DATA_W) +: DATA_W];
  assign size_ok = (size != '0) && (size <= MAXN_S);
  assign n_m1    = n_q - SW'(1);

  mac_signed #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (k_q == '0),
    .en    (state_q == ST_RUN),
    .a     (a_el),
    .b     (b_el),
    .sum   (sum)
  );

  always_comb begin
    ovf_el = (sum > SMAX) || (sum < SMIN);
    res    = sum[DATA_W-1:0];
    if (SATURATE != 0 && ovf_el) res = sum[ACC_W-1] ? SMIN[DATA_W-1:0] : SMAX[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    n_d = n_q; i_d = i_q; j_d = j_q; k_d = k_q;
    a_d = a_q; b_d = b_q; c_d = c_q;
    done_d = 1'b0; ovf_d = ovf_q; serr_d = serr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c_d   = '0;
          ovf_d = 1'b0;
          if (size_ok) begin
            a_d = A; b_d = B; n_d = size;
            i_d = '0; j_d = '0; k_d = '0;
            serr_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            serr_d = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (k_q == n_m1) begin
          c_d[elem_off(int'(i_q), int'(j_q), MAX_N, DATA_W) +: DATA_W] = res;
          ovf_d = ovf_q | ovf_el;
          k_d   = '0;
          if (j_q == n_m1) begin
            j_d = '0;
            if (i_q == n_m1) begin
              i_d     = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              i_d = i_q + SW'(1);
            end
          end else begin
            j_d = j_q + SW'(1);
          end
        end else begin
          k_d = k_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q <= '0; i_q <= '0; j_q <= '0; k_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0;
      done_q <= 1'b0; ovf_q <= 1'b0; serr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d; i_q <= i_d; j_q <= j_d; k_q <= k_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d;
      done_q <= done_d; ovf_q <= ovf_d; serr_q <= serr_d;
    end
  end

  assign C             = c_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = done_q;
  assign overflow_flag = ovf_q;
  assign size_err      = serr_q;
endmodule

// File: tb/tb_multiplicacao_matrizes_seq.sv
// Scoreboard bench: wrap and saturate instances driven together, checked against an arithmetic model.
module tb_multiplicacao_matrizes_seq;
  localparam int DW = 8;
  localparam int MN = 5;
  localparam int SW = 3;
  localparam int MW = MN * MN * DW;

  typedef struct {
    logic [MW-1:0] c;
    logic          ovf;
    logic          serr;
    int            cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [SW-1:0] size_i = '0;
  logic [MW-1:0] a_i = '0, b_i = '0;
  logic [MW-1:0] c0, c1;
  logic busy0, busy1, done0, done1, ovf0, ovf1, serr0, serr1;

  int checks = 0, failures = 0, cyc = 0;
  int ma[MN][MN], mb[MN][MN];
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplicacao_matrizes_seq #(.DATA_W(DW), .MAX_N(MN), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size_i), .A(a_i), .B(b_i),
    .C(c0), .busy(busy0), .done(done0), .overflow_flag(ovf0), .size_err(serr0));

  multiplicacao_matrizes_seq #(.DATA_W(DW), .MAX_N(MN), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size_i), .A(a_i), .B(b_i),
    .C(c1), .busy(busy1), .done(done1), .overflow_flag(ovf1), .size_err(serr1));

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int n, input int sat, input int dcyc);
    exp_t e;
    int s;
    logic [7:0] v;
    e.c = '0; e.ovf = 1'b0; e.serr = 1'b0; e.cyc = dcyc;
    if (n < 1 || n > MN) begin
      e.serr = 1'b1;
      return e;
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[i][k] * mb[k][j];
        if (s > 127 || s < -128) e.ovf = 1'b1;
        if (sat != 0 && s > 127) s = 127;
        if (sat != 0 && s < -128) s = -128;
        v = s[7:0];
        e.c[(i*MN+j)*DW +: DW] = v;
      end
    return e;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < MN; i++)
      for (int j = 0; j < MN; j++) begin
        a_i[(i*MN+j)*DW +: DW] = ma[i][j][7:0];
        b_i[(i*MN+j)*DW +: DW] = mb[i][j][7:0];
      end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MN; i++)
      for (int j = 0; j < MN; j++) begin
        ma[i][j] = int'($urandom_range(0, 255)) - 128;
        mb[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < MN; i++)
      for (int j = 0; j < MN; j++) begin
        ma[i][j] = v; mb[i][j] = v;
      end
  endtask

  // Call at a negedge where the DUTs are idle (or showing done).
  task automatic issue(input int n, output int dcyc);
    exp_t e;
    drive_ops();
    size_i = n[SW-1:0];
    start  = 1'b1;
    dcyc = (n >= 1 && n <= MN) ? cyc + 1 + n * n * n : cyc + 1;
    e = model(n, 0, dcyc); q0.push_back(e);
    e = model(n, 1, dcyc); q1.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d/%0d results still pending", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
  endtask

  task automatic mon(input int id, input logic [MW-1:0] c, input logic ovf,
                     input logic serr, input logic busy);
    exp_t e;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      checks++; failures++;
      $display("FAIL unexpected_done: dut%0d done with nothing expected (cyc %0d)", id, cyc);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("dut%0d C", id), c, e.c);
    check($sformatf("dut%0d overflow", id), MW'(ovf), MW'(e.ovf));
    check($sformatf("dut%0d size_err", id), MW'(serr), MW'(e.serr));
    check($sformatf("dut%0d done_cycle", id), MW'(cyc), MW'(e.cyc));
    check($sformatf("dut%0d busy_at_done", id), MW'(busy), '0);
  endtask

  always @(negedge clk) if (rst_n && done0) mon(0, c0, ovf0, serr0, busy0);
  always @(negedge clk) if (rst_n && done1) mon(1, c1, ovf1, serr1, busy1);

  task automatic check_zero(input string tag);
    check({tag, " C0"}, c0, '0);
    check({tag, " C1"}, c1, '0);
    check({tag, " flags"}, MW'({busy0, busy1, done0, done1, ovf0, ovf1, serr0, serr1}), '0);
  endtask

  initial begin
    int d;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // identity * [[1,2],[3,4]], garbage outside the 2x2 window
    fill_rand();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * 2 + j + 1;
      end
    issue(2, d); @(negedge clk) start = 1'b0; wait_idle();

    fill_const(127);  issue(3, d); @(negedge clk) start = 1'b0; wait_idle();
    fill_const(-128); issue(5, d); @(negedge clk) start = 1'b0; wait_idle();

    // abort a 5x5 run with reset around cycle 50
    fill_rand(); issue(5, d); @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero("midrun_reset");
    q0.delete(); q1.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_rand(); issue(2, d); @(negedge clk) start = 1'b0; wait_idle();

    foreach (ma[i]) ;
    issue(0, d); @(negedge clk) start = 1'b0; wait_idle();
    issue(6, d); @(negedge clk) start = 1'b0; wait_idle();
    issue(7, d); @(negedge clk) start = 1'b0; wait_idle();

    // start while busy must be ignored; changing operands mid-run must not matter
    fill_rand(); issue(3, d); @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    fill_rand(); drive_ops(); size_i = 3'd2; start = 1'b1;
    @(negedge clk) start = 1'b0;
    fill_rand(); drive_ops();
    wait_idle();

    // back-to-back: new start in the done cycle
    fill_rand(); issue(2, d); @(negedge clk) start = 1'b0;
    while (cyc < d) @(negedge clk);
    fill_rand(); issue(4, d); @(negedge clk) start = 1'b0;
    while (cyc < d) @(negedge clk);
    issue(0, d); @(negedge clk) start = 1'b0;
    wait_idle();

    for (int r = 0; r < 20; r++) begin
      fill_rand();
      if ($urandom_range(0, 3) == 0) fill_const(($urandom_range(0, 1) != 0) ? 127 : -128);
      issue(int'($urandom_range(0, 7)), d);
      @(negedge clk) start = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
